frame_fifo_read: RTL and testbench
==================================

Name: frame_fifo_read

Overview:
- Memory-to-FIFO frame reader: on a frame read request, issues burst reads to the external memory controller and streams the returned data into a downstream FIFO.
- Sits between the memory controller user interface and the video/data output FIFO.
- Counterpart of the frame write path: memory reads feed the FIFO write side.
- The FIFO write port is driven by rd_burst_data/rd_burst_data_valid outside this block; this block only controls bursts, addresses, FIFO clear and flow control.

Parameters:
MEM_DATA_BITS, 32, memory data width (informational; no data path inside)
ADDR_BITS, 23, memory word-address width
BUSRT_BITS, 10, burst length field width
BURST_SIZE, 256, maximum words per burst
FIFO_DEPTH, 1024, downstream FIFO capacity in words

Ports:
mem_clk  in  1  memory controller user clock; sole clock
rst  in  1  synchronous, active-low reset (0 = reset)
rd_burst_req  out  1  burst read request to memory controller
rd_burst_len  out  BUSRT_BITS  words in current burst
rd_burst_addr  out  ADDR_BITS  burst base word address
rd_burst_data_valid  in  1  controller returning a read data word
rd_burst_finish  in  1  burst complete pulse
read_req  in  1  async frame read request, held until read_req_ack
read_req_ack  out  1  request acknowledge
read_finish  out  1  one-cycle frame-done pulse
read_addr_0..read_addr_3  in  ADDR_BITS each  frame base addresses
read_addr_index  in  2  selects base address
read_len  in  ADDR_BITS  frame length in words
fifo_aclr  out  1  downstream FIFO clear
wr_data_count  in  16  FIFO write-side used words

Behaviour:
- Reset (rst=0 at mem_clk edge): all outputs 0, state S_IDLE, sync flops 0, counters 0.
- Synchronisers:
  - read_req passes through 3 flops (req_d2 used).
  - read_len and read_addr_index pass through 2 flops.
- S_IDLE: read_req_ack=0. If req_d2=1, go to S_ACK.
- S_ACK:
  - read_cnt<=0.
  - While req_d2=1: read_req_ack=1, fifo_aclr=1, rd_burst_addr<=read_addr_[index_d1], len_latch<=read_len_d1.
  - When req_d2=0: read_req_ack=0, fifo_aclr=0, go to S_CHECK_FIFO.
- S_CHECK_FIFO (priority order):
  - read_cnt>=len_latch: go to S_END (covers read_len=0).
  - Else req_d2=1: go to S_ACK.
  - Else wr_data_count <= FIFO_DEPTH-BURST_SIZE:
    - rd_burst_len <= min(BURST_SIZE, len_latch-read_cnt), truncated to BUSRT_BITS.
    - rd_burst_req<=1.
    - Go to S_READ_BURST.
  - Else stay (FIFO lacks space).
- S_READ_BURST:
  - rd_burst_req cleared on the first rd_burst_data_valid.
  - On rd_burst_finish: read_cnt += rd_burst_len; rd_burst_addr += rd_burst_len (mod 2^ADDR_BITS, wraps silently); go to S_READ_BURST_END.
  - A new read_req is not acted on until burst finish; bursts are never aborted.
  - If data_valid and finish coincide, both actions occur in that cycle.
- S_READ_BURST_END:
  - req_d2=1: go to S_ACK (restart frame).
  - Else read_cnt<len_latch: go to S_CHECK_FIFO.
  - Else go to S_END.
- S_END: read_finish=1 (combinational decode of state), go to S_IDLE.
- Undefined state codes: go to S_IDLE.
- Arithmetic: remaining = len_latch-read_cnt in ADDR_BITS unsigned; the min comparison is also in ADDR_BITS.
- Mid-operation reset: immediate return to reset values next edge. rd_burst_req drops; the controller must tolerate a dropped request.
- Latency: read_req rise to read_req_ack=1 is 4 mem_clk edges (3 sync + S_IDLE→S_ACK).

Test Plan:
- read_addr_index=1, read_addr_1=0x1000, read_len=512, wr_data_count=0 → two bursts: len 256 @0x1000, then len 256 @0x1100; then read_finish pulses once; fifo_aclr high only while ack high.
- read_len=300 → bursts of 256 @base, then 44 @base+256; read_finish after second rd_burst_finish.
- wr_data_count=800 (>768) → no rd_burst_req; drop wr_data_count to 768 → request on next cycle.
- read_len=0 → ack handshake, then S_CHECK_FIFO → read_finish without any rd_burst_req.
- New read_req during the first burst of a 1024-word frame → burst completes, then S_ACK; address reloaded, read_cnt=0, FIFO cleared.
- rst=0 mid-burst with rd_burst_req=1 → next edge: all outputs 0, state S_IDLE; a fresh request then runs normally.
- Base address 0x7FFF00, read_len=512 → second burst address wraps to 0x000000.

Source files
------------

// File: rtl/frame_fifo_read.sv
// frame_fifo_read: reads a frame from external memory as a sequence of bursts
// that feed the downstream FIFO, with request handshake, FIFO clear and
// FIFO-occupancy based flow control. The data path itself is outside this block.
module frame_fifo_read #(
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned ADDR_BITS     = 23,
  parameter int unsigned BUSRT_BITS    = 10,
  parameter int unsigned BURST_SIZE    = 256,
  parameter int unsigned FIFO_DEPTH    = 1024
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  output logic                  rd_burst_req,
  output logic [BUSRT_BITS-1:0] rd_burst_len,
  output logic [ADDR_BITS-1:0]  rd_burst_addr,
  input  logic                  rd_burst_data_valid,
  input  logic                  rd_burst_finish,
  input  logic                  read_req,
  output logic                  read_req_ack,
  output logic                  read_finish,
  input  logic [ADDR_BITS-1:0]  read_addr_0,
  input  logic [ADDR_BITS-1:0]  read_addr_1,
  input  logic [ADDR_BITS-1:0]  read_addr_2,
  input  logic [ADDR_BITS-1:0]  read_addr_3,
  input  logic [1:0]            read_addr_index,
  input  logic [ADDR_BITS-1:0]  read_len,
  output logic                  fifo_aclr,
  input  logic [15:0]           wr_data_count
);

  // FIFO must have room for a full burst before one is issued
  localparam logic [15:0]          FIFO_THRESH = 16'(FIFO_DEPTH - BURST_SIZE);
  localparam logic [ADDR_BITS-1:0] BURST_WORDS = ADDR_BITS'(BURST_SIZE);

  // Elaboration guard on parameter consistency
  if (MEM_DATA_BITS == 0 || BURST_SIZE >= (1 << BUSRT_BITS) || BURST_SIZE > FIFO_DEPTH) begin : g_bad_params
    $error("frame_fifo_read: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_ACK            = 3'd1,
    S_CHECK_FIFO     = 3'd2,
    S_READ_BURST     = 3'd3,
    S_READ_BURST_END = 3'd4,
    S_END            = 3'd5
  } state_t;

  state_t state, state_n;

  logic                  req_d0, req_d1, req_d2;
  logic [1:0]            index_d0, index_d1;
  logic [ADDR_BITS-1:0]  len_d0, len_d1;

  logic [ADDR_BITS-1:0]  read_cnt, read_cnt_n;
  logic [ADDR_BITS-1:0]  len_latch, len_latch_n;
  logic [ADDR_BITS-1:0]  remaining;
  logic [ADDR_BITS-1:0]  base_addr;
  logic                  burst_req_n;
  logic [BUSRT_BITS-1:0] burst_len_n;
  logic [ADDR_BITS-1:0]  burst_addr_n;
  logic                  ack_n;
  logic                  aclr_n;

  // Bring the request and frame settings into the mem_clk domain
  always_ff @(posedge mem_clk) begin
    if (!rst) begin
      req_d0   <= 1'b0;
      req_d1   <= 1'b0;
      req_d2   <= 1'b0;
      index_d0 <= 2'd0;
      index_d1 <= 2'd0;
      len_d0   <= '0;
      len_d1   <= '0;
    end else begin
      req_d0   <= read_req;
      req_d1   <= req_d0;
      req_d2   <= req_d1;
      index_d0 <= read_addr_index;
      index_d1 <= index_d0;
      len_d0   <= read_len;
      len_d1   <= len_d0;
    end
  end

  // Frame base address selected by the synchronised index
  always_comb begin
    base_addr = read_addr_0;
    case (index_d1)
      2'd0:    base_addr = read_addr_0;
      2'd1:    base_addr = read_addr_1;
      2'd2:    base_addr = read_addr_2;
      default: base_addr = read_addr_3;
    endcase
  end

  // State and registered-output update
  always_ff @(posedge mem_clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      read_cnt      <= '0;
      len_latch     <= '0;
      rd_burst_req  <= 1'b0;
      rd_burst_len  <= '0;
      rd_burst_addr <= '0;
      read_req_ack  <= 1'b0;
      fifo_aclr     <= 1'b0;
    end else begin
      state         <= state_n;
      read_cnt      <= read_cnt_n;
      len_latch     <= len_latch_n;
      rd_burst_req  <= burst_req_n;
      rd_burst_len  <= burst_len_n;
      rd_burst_addr <= burst_addr_n;
      read_req_ack  <= ack_n;
      fifo_aclr     <= aclr_n;
    end
  end

  // Next-state and next-value decode for the frame read sequence
  always_comb begin
    state_n      = state;
    read_cnt_n   = read_cnt;
    len_latch_n  = len_latch;
    burst_req_n  = rd_burst_req;
    burst_len_n  = rd_burst_len;
    burst_addr_n = rd_burst_addr;
    remaining    = len_latch - read_cnt;

    case (state)
      S_IDLE: begin
        if (req_d2) state_n = S_ACK;
      end
      S_ACK: begin
        read_cnt_n = '0;
        if (req_d2) begin
          burst_addr_n = base_addr;
          len_latch_n  = len_d1;
        end else begin
          state_n = S_CHECK_FIFO;
        end
      end
      S_CHECK_FIFO: begin
        if (read_cnt >= len_latch) begin
          state_n = S_END;
        end else if (req_d2) begin
          state_n = S_ACK;
        end else if (wr_data_count <= FIFO_THRESH) begin
          burst_len_n = (remaining >= BURST_WORDS) ? BUSRT_BITS'(BURST_SIZE)
                                                   : BUSRT_BITS'(remaining);
          burst_req_n = 1'b1;
          state_n     = S_READ_BURST;
        end
      end
      S_READ_BURST: begin
        // Request is withdrawn once the controller starts returning data
        if (rd_burst_data_valid) burst_req_n = 1'b0;
        if (rd_burst_finish) begin
          read_cnt_n   = read_cnt + ADDR_BITS'(rd_burst_len);
          burst_addr_n = rd_burst_addr + ADDR_BITS'(rd_burst_len);
          state_n      = S_READ_BURST_END;
        end
      end
      S_READ_BURST_END: begin
        if (req_d2)                     state_n = S_ACK;
        else if (read_cnt < len_latch)  state_n = S_CHECK_FIFO;
        else                            state_n = S_END;
      end
      S_END: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Ack and FIFO clear are held for as long as the handshake is in progress
    ack_n  = (state_n == S_ACK) && req_d2;
    aclr_n = (state_n == S_ACK) && req_d2;
  end

  // Frame-done pulse is a direct decode of the end state
  assign read_finish = (state == S_END);

endmodule

// File: tb/tb_frame_fifo_read.sv
// Directed testbench for frame_fifo_read with a simple memory-controller responder.
module tb_frame_fifo_read;

  logic        mem_clk;
  logic        rst;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [22:0] rd_burst_addr;
  logic        rd_burst_data_valid;
  logic        rd_burst_finish;
  logic        read_req;
  logic        read_req_ack;
  logic        read_finish;
  logic [22:0] read_addr_0, read_addr_1, read_addr_2, read_addr_3;
  logic [1:0]  read_addr_index;
  logic [22:0] read_len;
  logic        fifo_aclr;
  logic [15:0] wr_data_count;

  int checks = 0;
  int errors = 0;
  int fin_cnt = 0;
  int fin_mark = 0;
  int req_seen = 0;
  int aclr_bad = 0;

  frame_fifo_read dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_finish     (rd_burst_finish),
    .read_req            (read_req),
    .read_req_ack        (read_req_ack),
    .read_finish         (read_finish),
    .read_addr_0         (read_addr_0),
    .read_addr_1         (read_addr_1),
    .read_addr_2         (read_addr_2),
    .read_addr_3         (read_addr_3),
    .read_addr_index     (read_addr_index),
    .read_len            (read_len),
    .fifo_aclr           (fifo_aclr),
    .wr_data_count       (wr_data_count)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Background observation of pulses and the clear/ack relationship
  always @(negedge mem_clk) begin
    if (read_finish) fin_cnt++;
    if (rd_burst_req) req_seen++;
    if (fifo_aclr !== read_req_ack) aclr_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"},  32'(rd_burst_req),  32'd0);
    chk({tag, "_len"},  32'(rd_burst_len),  32'd0);
    chk({tag, "_addr"}, 32'(rd_burst_addr), 32'd0);
    chk({tag, "_ack"},  32'(read_req_ack),  32'd0);
    chk({tag, "_aclr"}, 32'(fifo_aclr),     32'd0);
    chk({tag, "_fin"},  32'(read_finish),   32'd0);
  endtask

  // Full request/acknowledge handshake, checking latency and FIFO clear
  task automatic do_req(input string tag);
    int n;
    fin_mark = fin_cnt;
    @(negedge mem_clk);
    read_req = 1'b1;
    n = 0;
    do begin
      @(negedge mem_clk);
      n++;
    end while (!read_req_ack && n < 20);
    chk({tag, "_ack_lat"}, 32'(n), 32'd4);
    chk({tag, "_aclr_hi"}, 32'(fifo_aclr), 32'd1);
    read_req = 1'b0;
    n = 0;
    while (read_req_ack && n < 20) begin
      @(negedge mem_clk);
      n++;
    end
    chk({tag, "_ack_lo"}, 32'(read_req_ack), 32'd0);
  endtask

  // Wait for a burst request, check it, then return el data words with finish on the last
  task automatic run_burst(input string tag, input logic [22:0] ea, input logic [9:0] el);
    int n;
    n = 0;
    while (!rd_burst_req && n < 200) begin
      @(negedge mem_clk);
      n++;
    end
    chk({tag, "_req"}, 32'(rd_burst_req), 32'd1);
    if (rd_burst_req) begin
      chk({tag, "_addr"}, 32'(rd_burst_addr), 32'(ea));
      chk({tag, "_len"},  32'(rd_burst_len),  32'(el));
      for (int i = 0; i < int'(el); i++) begin
        rd_burst_data_valid = 1'b1;
        rd_burst_finish     = (i == int'(el) - 1);
        @(negedge mem_clk);
        if (i == 0) chk({tag, "_req_drop"}, 32'(rd_burst_req), 32'd0);
      end
      rd_burst_data_valid = 1'b0;
      rd_burst_finish     = 1'b0;
    end
  endtask

  task automatic wait_finish(input string tag);
    int n;
    n = 0;
    while (!read_finish && n < 50) begin
      @(negedge mem_clk);
      n++;
    end
    chk({tag, "_finish"}, 32'(read_finish), 32'd1);
    repeat (3) @(negedge mem_clk);
    chk({tag, "_fin_once"}, 32'(fin_cnt), 32'(fin_mark + 1));
  endtask

  initial begin
    int n;
    int seen0;
    rst = 1'b0;
    read_req = 1'b0;
    rd_burst_data_valid = 1'b0;
    rd_burst_finish = 1'b0;
    read_addr_0 = 23'h0;
    read_addr_1 = 23'h0;
    read_addr_2 = 23'h0;
    read_addr_3 = 23'h0;
    read_addr_index = 2'd0;
    read_len = 23'd0;
    wr_data_count = 16'd0;

    repeat (3) @(negedge mem_clk);
    chk_outputs_zero("rst");
    rst = 1'b1;
    repeat (2) @(negedge mem_clk);

    // Two full bursts from index 1
    read_addr_1 = 23'h001000;
    read_addr_index = 2'd1;
    read_len = 23'd512;
    do_req("f512");
    run_burst("f512_b0", 23'h001000, 10'd256);
    run_burst("f512_b1", 23'h001100, 10'd256);
    wait_finish("f512");

    // Partial last burst
    read_len = 23'd300;
    do_req("f300");
    run_burst("f300_b0", 23'h001000, 10'd256);
    run_burst("f300_b1", 23'h001100, 10'd44);
    wait_finish("f300");

    // FIFO too full, then exactly at threshold
    read_addr_0 = 23'h000040;
    read_addr_index = 2'd0;
    read_len = 23'd16;
    wr_data_count = 16'd800;
    do_req("full");
    repeat (10) @(negedge mem_clk);
    chk("full_no_req", 32'(rd_burst_req), 32'd0);
    wr_data_count = 16'd768;
    @(negedge mem_clk);
    chk("full_req_next", 32'(rd_burst_req), 32'd1);
    run_burst("full_b0", 23'h000040, 10'd16);
    wr_data_count = 16'd0;
    wait_finish("full");

    // Zero-length frame
    read_len = 23'd0;
    seen0 = req_seen;
    do_req("zero");
    wait_finish("zero");
    chk("zero_no_req", 32'(req_seen), 32'(seen0));

    // Restart request during the first burst of a long frame
    read_addr_0 = 23'h002000;
    read_addr_index = 2'd0;
    read_len = 23'd1024;
    do_req("rs");
    read_req = 1'b1;
    read_addr_2 = 23'h003000;
    read_addr_index = 2'd2;
    read_len = 23'd300;
    run_burst("rs_b0", 23'h002000, 10'd256);
    n = 0;
    while (!read_req_ack && n < 20) begin
      @(negedge mem_clk);
      n++;
    end
    chk("rs_ack", 32'(read_req_ack), 32'd1);
    chk("rs_aclr", 32'(fifo_aclr), 32'd1);
    read_req = 1'b0;
    n = 0;
    while (read_req_ack && n < 20) begin
      @(negedge mem_clk);
      n++;
    end
    run_burst("rs_b1", 23'h003000, 10'd256);
    run_burst("rs_b2", 23'h003100, 10'd44);
    wait_finish("rs");

    // Reset while a burst request is pending, then a clean frame
    read_addr_1 = 23'h000500;
    read_addr_index = 2'd1;
    read_len = 23'd64;
    do_req("mr");
    n = 0;
    while (!rd_burst_req && n < 20) begin
      @(negedge mem_clk);
      n++;
    end
    chk("mr_req_up", 32'(rd_burst_req), 32'd1);
    rst = 1'b0;
    @(negedge mem_clk);
    chk_outputs_zero("mr_rst");
    rst = 1'b1;
    @(negedge mem_clk);
    do_req("mr2");
    run_burst("mr2_b0", 23'h000500, 10'd64);
    wait_finish("mr2");

    // Address wrap at the top of memory
    read_addr_3 = 23'h7FFF00;
    read_addr_index = 2'd3;
    read_len = 23'd512;
    do_req("wrap");
    run_burst("wrap_b0", 23'h7FFF00, 10'd256);
    run_burst("wrap_b1", 23'h000000, 10'd256);
    wait_finish("wrap");

    chk("aclr_tracks_ack", 32'(aclr_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
